// File: rtl/riscv_state_pkg.sv
// Shared privilege / PMP definitions for the machine-mode state block.
//  - pmp_a_e    : pmpcfg address-matching mode (OFF/TOR/NA4/NAPOT)
//  - pmpcfg_t   : one pmpcfg byte (L, reserved[1:0], A, X, W, R)
//  - PRV_*      : privilege encodings
//  - PMPCFG*/PMPADDR* : CSR addresses of the PMP bank
package riscv_state_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TOR   = 2'd1,
        NA4   = 2'd2,
        NAPOT = 2'd3
    } pmp_a_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_a_e     a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    localparam logic [1:0] PRV_U = 2'd0;
    localparam logic [1:0] PRV_S = 2'd1;
    localparam logic [1:0] PRV_M = 2'd3;

    localparam logic [11:0] PMPCFG0   = 12'h3A0;
    localparam logic [11:0] PMPCFG1   = 12'h3A1;
    localparam logic [11:0] PMPCFG2   = 12'h3A2;
    localparam logic [11:0] PMPCFG3   = 12'h3A3;
    localparam logic [11:0] PMPADDR0  = 12'h3B0;
    localparam logic [11:0] PMPADDR1  = 12'h3B1;
    localparam logic [11:0] PMPADDR2  = 12'h3B2;
    localparam logic [11:0] PMPADDR3  = 12'h3B3;
    localparam logic [11:0] PMPADDR4  = 12'h3B4;
    localparam logic [11:0] PMPADDR5  = 12'h3B5;
    localparam logic [11:0] PMPADDR6  = 12'h3B6;
    localparam logic [11:0] PMPADDR7  = 12'h3B7;
    localparam logic [11:0] PMPADDR8  = 12'h3B8;
    localparam logic [11:0] PMPADDR9  = 12'h3B9;
    localparam logic [11:0] PMPADDR10 = 12'h3BA;
    localparam logic [11:0] PMPADDR11 = 12'h3BB;
    localparam logic [11:0] PMPADDR12 = 12'h3BC;
    localparam logic [11:0] PMPADDR13 = 12'h3BD;
    localparam logic [11:0] PMPADDR14 = 12'h3BE;
    localparam logic [11:0] PMPADDR15 = 12'h3BF;

endpackage

// File: rtl/riscv_pmp_entry.sv
// One PMP entry: pmpcfg byte + pmpaddr register with lock qualification
// and WARL legalisation.
// Ports:
//  clk, rst          clock, asynchronous active-high reset
//  cfg_we_i          write strobe for this entry's pmpcfg byte
//  cfg_wdata_i       raw byte from the CSR write data
//  addr_we_i         write strobe for this entry's pmpaddr
//  addr_wdata_i      raw pmpaddr write data
//  next_tor_lock_i   entry i+1 is locked in TOR mode (pre-write state)
//  cfg_o, addr_o     stored state
//  changed_o         the pending write alters at least one stored bit
module riscv_pmp_entry
    import riscv_state_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PLEN = (XLEN == 32) ? 34 : 56
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we_i,
    input  logic [7:0]      cfg_wdata_i,
    input  logic            addr_we_i,
    input  logic [XLEN-1:0] addr_wdata_i,
    input  logic            next_tor_lock_i,
    output pmpcfg_t         cfg_o,
    output logic [XLEN-1:0] addr_o,
    output logic            changed_o
);

    pmpcfg_t         cfg_q, cfg_d, cfg_legal;
    logic [XLEN-1:0] addr_q, addr_d, addr_legal;

    always_comb begin
        cfg_legal      = pmpcfg_t'(cfg_wdata_i);
        cfg_legal.rsvd = 2'b00;
        // W without R is reserved; keep the rest of the byte, drop W.
        if (cfg_legal.w && !cfg_legal.r) begin
            cfg_legal.w = 1'b0;
        end

        // Only address bits [PLEN-1:2] exist, i.e. wdata[PLEN-3:0].
        addr_legal = '0;
        for (int b = 0; b < XLEN; b++) begin
            addr_legal[b] = (b < PLEN - 2) ? addr_wdata_i[b] : 1'b0;
        end

        // Lock decisions are taken on the current (pre-write) state.
        cfg_d  = (cfg_we_i && !cfg_q.l) ? cfg_legal : cfg_q;
        addr_d = (addr_we_i && !cfg_q.l && !next_tor_lock_i) ? addr_legal : addr_q;

        changed_o = (cfg_d != cfg_q) || (addr_d != addr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q  <= '0;
            addr_q <= '0;
        end else begin
            cfg_q  <= cfg_d;
            addr_q <= addr_d;
        end
    end

    assign cfg_o  = cfg_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/riscv_pmp_csr.sv
// Machine-mode PMP CSR bank: owns pmpcfg*/pmpaddr*, serves CSR accesses
// from the execute stage and publishes the registered PMP state.
// Ports:
//  clk, rst                    clock, asynchronous active-high reset
//  st_prv_i                    current privilege level
//  csr_req_i/we_i/adr_i/wdata_i  CSR access request (one per cycle)
//  csr_ack_o/illegal_o/rdata_o   registered response, one cycle later
//  st_pmpcfg_o, st_pmpaddr_o   current per-entry configuration/address
//  pmp_update_o                one-cycle pulse after a state-changing write
module riscv_pmp_csr
    import riscv_state_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PLEN    = (XLEN == 32) ? 34 : 56,
    parameter int PMP_CNT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      st_prv_i,
    input  logic            csr_req_i,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_adr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic            csr_ack_o,
    output logic            csr_illegal_o,
    output logic [XLEN-1:0] csr_rdata_o,
    output pmpcfg_t [((PMP_CNT > 0) ? PMP_CNT : 1)-1:0]            st_pmpcfg_o,
    output logic    [((PMP_CNT > 0) ? PMP_CNT : 1)-1:0][XLEN-1:0]  st_pmpaddr_o,
    output logic            pmp_update_o
);

    // Arrays keep at least one slot so PMP_CNT=0 still elaborates.
    localparam int N_ARR = (PMP_CNT > 0) ? PMP_CNT : 1;
    localparam int EPR   = XLEN / 8;   // entries per pmpcfg register

    pmpcfg_t [N_ARR-1:0]            cfg_arr;
    logic    [N_ARR-1:0][XLEN-1:0]  addr_arr;
    logic    [N_ARR-1:0]            cfg_we, addr_we, changed;
    logic    [N_ARR-1:0][7:0]       cfg_byte;

    logic            cfg_hit, addr_hit, legal, wr;
    logic [3:0]      cfg_base, addr_idx;
    logic [XLEN-1:0] rd_mux;

    logic            ack_q, ack_d, illegal_q, illegal_d, update_q, update_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    always_comb begin
        // On RV64 only the even pmpcfg registers exist.
        cfg_hit  = ((csr_adr_i & 12'hFFC) == PMPCFG0) && !((XLEN == 64) && csr_adr_i[0]);
        addr_hit = (csr_adr_i & 12'hFF0) == PMPADDR0;
        legal    = (st_prv_i == PRV_M) && (cfg_hit || addr_hit);
        wr       = csr_req_i && csr_we_i && legal;
        // pmpcfgN covers entries 4N.. on RV32; pmpcfg0/2 -> 0/8 on RV64 too.
        cfg_base = {csr_adr_i[1:0], 2'b00};
        addr_idx = csr_adr_i[3:0];

        rd_mux = '0;
        for (int i = 0; i < N_ARR; i++) begin
            cfg_we[i]   = 1'b0;
            addr_we[i]  = 1'b0;
            cfg_byte[i] = '0;
            if (i < PMP_CNT) begin
                if (cfg_hit && (i >= int'(cfg_base)) && (i < int'(cfg_base) + EPR)) begin
                    cfg_we[i]   = wr;
                    cfg_byte[i] = 8'(csr_wdata_i >> ((i - int'(cfg_base)) * 8));
                    rd_mux      = rd_mux | (XLEN'(cfg_arr[i]) << ((i - int'(cfg_base)) * 8));
                end
                if (addr_hit && (addr_idx == 4'(i))) begin
                    addr_we[i] = wr;
                    rd_mux     = addr_arr[i];
                end
            end
        end

        ack_d     = csr_req_i;
        illegal_d = csr_req_i && !legal;
        rdata_d   = (csr_req_i && legal) ? rd_mux : '0;
        update_d  = |changed;
    end

    for (genvar gi = 0; gi < N_ARR; gi++) begin : g_entry
        if (gi < PMP_CNT) begin : g_impl
            logic next_tor_lock;
            // A locked TOR entry also protects the pmpaddr below it.
            if (gi + 1 < PMP_CNT) begin : g_next
                assign next_tor_lock = cfg_arr[gi+1].l && (cfg_arr[gi+1].a == TOR);
            end else begin : g_last
                assign next_tor_lock = 1'b0;
            end

            riscv_pmp_entry #(
                .XLEN (XLEN),
                .PLEN (PLEN)
            ) u_entry (
                .clk             (clk),
                .rst             (rst),
                .cfg_we_i        (cfg_we[gi]),
                .cfg_wdata_i     (cfg_byte[gi]),
                .addr_we_i       (addr_we[gi]),
                .addr_wdata_i    (csr_wdata_i),
                .next_tor_lock_i (next_tor_lock),
                .cfg_o           (cfg_arr[gi]),
                .addr_o          (addr_arr[gi]),
                .changed_o       (changed[gi])
            );
        end else begin : g_none
            assign cfg_arr[gi]  = '0;
            assign addr_arr[gi] = '0;
            assign changed[gi]  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q     <= 1'b0;
            illegal_q <= 1'b0;
            rdata_q   <= '0;
            update_q  <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            illegal_q <= illegal_d;
            rdata_q   <= rdata_d;
            update_q  <= update_d;
        end
    end

    assign csr_ack_o     = ack_q;
    assign csr_illegal_o = illegal_q;
    assign csr_rdata_o   = rdata_q;
    assign pmp_update_o  = update_q;
    assign st_pmpcfg_o   = cfg_arr;
    assign st_pmpaddr_o  = addr_arr;

endmodule

// File: tb/tb_riscv_pmp_csr.sv
// Directed bench for riscv_pmp_csr. Main instance is RV32/16 entries and
// is checked through a response scoreboard; a PMP_CNT=4 and an XLEN=64
// instance share the stimulus and are spot-checked directly.
module tb_riscv_pmp_csr;
    import riscv_state_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  prv;
    logic        req, we;
    logic [11:0] adr;
    logic [31:0] wdata;

    logic                  ack, ill, upd;
    logic [31:0]           rdata;
    pmpcfg_t [15:0]        cfg;
    logic [15:0][31:0]     paddr;

    logic                  ack4, ill4, upd4;
    logic [31:0]           rdata4;
    pmpcfg_t [3:0]         cfg4;
    logic [3:0][31:0]      paddr4;

    logic                  ack64, ill64, upd64;
    logic [63:0]           rdata64;
    pmpcfg_t [15:0]        cfg64;
    logic [15:0][63:0]     paddr64;

    riscv_pmp_csr dut (
        .clk(clk), .rst(rst), .st_prv_i(prv), .csr_req_i(req), .csr_we_i(we),
        .csr_adr_i(adr), .csr_wdata_i(wdata), .csr_ack_o(ack), .csr_illegal_o(ill),
        .csr_rdata_o(rdata), .st_pmpcfg_o(cfg), .st_pmpaddr_o(paddr), .pmp_update_o(upd)
    );

    riscv_pmp_csr #(.PMP_CNT(4)) dut4 (
        .clk(clk), .rst(rst), .st_prv_i(prv), .csr_req_i(req), .csr_we_i(we),
        .csr_adr_i(adr), .csr_wdata_i(wdata), .csr_ack_o(ack4), .csr_illegal_o(ill4),
        .csr_rdata_o(rdata4), .st_pmpcfg_o(cfg4), .st_pmpaddr_o(paddr4), .pmp_update_o(upd4)
    );

    riscv_pmp_csr #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .st_prv_i(prv), .csr_req_i(req), .csr_we_i(we),
        .csr_adr_i(adr), .csr_wdata_i({32'h0, wdata}), .csr_ack_o(ack64), .csr_illegal_o(ill64),
        .csr_rdata_o(rdata64), .st_pmpcfg_o(cfg64), .st_pmpaddr_o(paddr64), .pmp_update_o(upd64)
    );

    typedef struct {
        int          id;
        logic        ill;
        logic        upd;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   seq   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Request is presented just after a rising edge and sampled on the next.
    task automatic drive(input logic [1:0] p, input logic w, input logic [11:0] a,
                         input logic [31:0] d, input logic e_ill, input logic e_upd,
                         input logic c_rd, input logic [31:0] e_rd);
        exp_t e;
        @(posedge clk);
        #1;
        prv = p; req = 1'b1; we = w; adr = a; wdata = d;
        e.id = seq; e.ill = e_ill; e.upd = e_upd; e.chk_rd = c_rd; e.rd = e_rd;
        sb.push_back(e);
        $display("txn %0d: prv=%0d we=%0b adr=0x%h wdata=0x%h", seq, p, w, a, d);
        seq++;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic e_upd);
        drive(PRV_M, 1'b1, a, d, 1'b0, e_upd, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e_rd);
        drive(PRV_M, 1'b0, a, 32'h0, 1'b0, 1'b0, 1'b1, e_rd);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        req = 1'b0;
        we  = 1'b0;
    endtask

    // Response monitor: compare each ack against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 64'(ack), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("illegal#%0d", e.id), 64'(ill), 64'(e.ill));
                    chk($sformatf("update#%0d", e.id), 64'(upd), 64'(e.upd));
                    if (e.chk_rd) chk($sformatf("rdata#%0d", e.id), 64'(rdata), 64'(e.rd));
                end
            end else if (upd) begin
                chk("stray_update", 64'(upd), 64'(0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        prv = PRV_M; req = 1'b0; we = 1'b0; adr = '0; wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // 1: reset state
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_illegal", 64'(ill), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_update", 64'(upd), 64'(0));
        chk("rst_cfg_any", 64'(|cfg), 64'(0));
        chk("rst_addr_any", 64'(|paddr), 64'(0));
        rst = 1'b0;
        rd(12'h3A0, 32'h0);
        rd(12'h3B5, 32'h0);
        idle();

        // 2: RV32 pmpcfg0 write, readback, repeated no-op write
        wr(12'h3A0, 32'h0000_1F0B, 1'b1);
        idle();
        chk("cfg0_0B", 64'(cfg[0]), 64'h0B);
        chk("cfg1_1F", 64'(cfg[1]), 64'h1F);
        rd(12'h3A0, 32'h0000_1F0B);
        wr(12'h3A0, 32'h0000_1F0B, 1'b0);
        idle();

        // 3: WARL legalisation
        wr(12'h3A0, 32'h0000_0002, 1'b1);
        idle();
        chk("cfg0_rw_reserved", 64'(cfg[0]), 64'h00);
        wr(12'h3A0, 32'h0000_0063, 1'b1);
        idle();
        chk("cfg0_bits65_clear", 64'(cfg[0]), 64'h03);

        // 4: lock on entry1 (TOR) protects pmpaddr1 and pmpaddr0
        wr(12'h3B0, 32'h0000_0100, 1'b1);
        wr(12'h3B1, 32'h0000_0200, 1'b1);
        wr(12'h3A0, 32'h0000_8903, 1'b1);
        wr(12'h3B1, 32'h0000_0FFF, 1'b0);
        wr(12'h3B0, 32'h0000_0ABC, 1'b0);
        rd(12'h3B1, 32'h0000_0200);
        rd(12'h3B0, 32'h0000_0100);
        wr(12'h3A0, 32'h0000_0007, 1'b1);
        rd(12'h3A0, 32'h0000_8907);
        idle();
        chk("cfg1_locked", 64'(cfg[1]), 64'h89);
        chk("addr0_kept", 64'(paddr[0]), 64'h100);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_cfg_any", 64'(|cfg), 64'(0));
        rst = 1'b0;
        wr(12'h3B1, 32'h0000_0055, 1'b1);
        rd(12'h3B1, 32'h0000_0055);
        idle();

        // 5: illegal privilege / address
        drive(PRV_U, 1'b1, 12'h3B2, 32'h0000_1234, 1'b1, 1'b0, 1'b1, 32'h0);
        idle();
        chk("addr2_unchanged", 64'(paddr[2]), 64'h0);
        drive(PRV_M, 1'b0, 12'h3A4, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
        rd(12'h3A1, 32'h0);
        idle();
        chk("rv64_3A1_ack", 64'(ack64), 64'(1));
        chk("rv64_3A1_illegal", 64'(ill64), 64'(1));
        rd(12'h3A2, 32'h0);
        idle();
        chk("rv64_3A2_illegal", 64'(ill64), 64'(0));

        // 6: full-width pmpaddr, back-to-back write then read
        wr(12'h3B3, 32'hFFFF_FFFF, 1'b1);
        rd(12'h3B3, 32'hFFFF_FFFF);
        idle();
        chk("addr3_full", 64'(paddr[3]), 64'hFFFF_FFFF);
        wr(12'h3B8, 32'h0000_1234, 1'b1);
        idle();
        chk("cnt4_wr_ack", 64'(ack4), 64'(1));
        chk("cnt4_wr_update", 64'(upd4), 64'(0));
        rd(12'h3B8, 32'h0000_1234);
        idle();
        chk("cnt4_rd_illegal", 64'(ill4), 64'(0));
        chk("cnt4_rd_rdata", 64'(rdata4), 64'(0));

        idle();
        idle();
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
